prastara_enumerator: RTL

Streaming Prastāra generator: given pattern length n and Guru count k, emits every n-bit Laghu(0)/Guru(1) pattern containing exactly k Gurus, in ascending numeric order, one per cycle under valid/ready flow control, each tagged with its rank. It sits directly downstream of the Pingala binary unit. That unit supplies C(n,k) as the expected Sankhyā count, and this block produces the patterns that count describes, feeding encryption, compression and code-word consumers.

---
 rtl/pingala_pkg.sv | 15 +
 rtl/pingala_next_comb.sv | 35 +++
 rtl/prastara_enumerator.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pingala_pkg.sv
// Shared Pingala definitions: size defaults, enumerator state encoding and Meru-table width.
package pingala_pkg;

  localparam int unsigned MAX_N_DEFAULT     = 16;
  localparam int unsigned CNT_WIDTH_DEFAULT = 32;
  // Wide enough for C(16,8); the binary unit sizes its Meru entries with this too.
  localparam int unsigned MERU_WIDTH        = 16;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    FINISH
  } state_t;

endpackage

// File: rtl/pingala_next_comb.sv
// Combinational Prastara successor: the next larger value with the same Guru count (Gosper step).
module pingala_next_comb #(
  parameter int unsigned MAX_N = 16
) (
  input  logic [MAX_N-1:0] x,
  output logic [MAX_N-1:0] next
);

  localparam int unsigned W  = MAX_N + 1;
  localparam int unsigned CW = $clog2(MAX_N + 1);

  logic [W-1:0]  xe;
  logic [W-1:0]  c;
  logic [W-1:0]  r;
  logic [CW-1:0] ctz;
  logic          found;

  always_comb begin
    ctz   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (x[i] && !found) begin
        ctz   = i[CW-1:0];
        found = 1'b1;
      end
    end
  end

  // One spare bit so the ripple add cannot overflow; the shift by ctz stands in for division by c.
  assign xe   = {1'b0, x};
  assign c    = xe & (~xe + W'(1));
  assign r    = xe + c;
  assign next = MAX_N'((((r ^ xe) >> 2) >> ctz) | r);

endmodule

// File: rtl/prastara_enumerator.sv
// Streams every n-bit pattern with exactly k Gurus in ascending order, tagged with its rank.
// Optional self-check enabled by defining PRASTARA_SELFCHECK_EN.
module prastara_enumerator
  import pingala_pkg::*;
#(
  parameter int unsigned MAX_N     = MAX_N_DEFAULT,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [4:0]           n_value,
  input  logic [4:0]           k_value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MAX_N-1:0]     out_pattern,
  output logic [CNT_WIDTH-1:0] out_rank,
  output logic                 out_last,
  output logic [CNT_WIDTH-1:0] total_count,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 chk_fail
);

  state_t           state;
  logic [MAX_N-1:0] last_q;
  logic [MAX_N-1:0] next_pat;
  logic [MAX_N-1:0] first_pat;
  logic [MAX_N-1:0] final_pat;
  logic             start_bad;

  function automatic logic [MAX_N-1:0] low_ones(input logic [4:0] k);
    logic [MAX_N:0] one;
    one      = (MAX_N + 1)'(1);
    low_ones = MAX_N'((one << k) - one);
  endfunction

  assign first_pat = low_ones(k_value);
  assign final_pat = first_pat << (n_value - k_value);
  assign start_bad = (n_value == '0) || (32'(n_value) > MAX_N) || (k_value > n_value);

  pingala_next_comb #(.MAX_N(MAX_N)) u_next (
    .x    (out_pattern),
    .next (next_pat)
  );

  // The final pattern is fixed at start, so out_last is registered alongside each new pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_q      <= '0;
      out_valid   <= 1'b0;
      out_pattern <= '0;
      out_rank    <= '0;
      out_last    <= 1'b0;
      total_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (start_bad) begin
              state <= FINISH;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              last_q      <= final_pat;
              out_pattern <= first_pat;
              out_rank    <= '0;
              total_count <= '0;
              out_last    <= (first_pat == final_pat);
              out_valid   <= 1'b1;
              busy        <= 1'b1;
              state       <= EMIT;
            end
          end
        end
        EMIT: begin
          if (abort) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
          end else if (out_ready) begin
            total_count <= total_count + CNT_WIDTH'(1);
            if (out_last) begin
              state     <= FINISH;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_pattern <= next_pat;
              out_rank    <= out_rank + CNT_WIDTH'(1);
              out_last    <= (next_pat == last_q);
            end
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PRASTARA_SELFCHECK_EN
  logic [4:0]            n_q;
  logic [4:0]            k_q;
  logic [MAX_N-1:0]      prev_q;
  logic [MERU_WIDTH-1:0] meru_row [0:MAX_N];
  logic [MERU_WIDTH-1:0] meru_nk;

  // Meru row n built in place; descending j keeps row r-1 values readable.
  always_comb begin
    for (int unsigned j = 0; j <= MAX_N; j++)
      meru_row[j] = (j == 0) ? MERU_WIDTH'(1) : '0;
    for (int unsigned r = 1; r <= MAX_N; r++)
      if (r <= 32'(n_q))
        for (int unsigned j = MAX_N; j >= 1; j--)
          meru_row[j] = meru_row[j] + meru_row[j-1];
    meru_nk = meru_row[k_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_fail <= 1'b0;
      n_q      <= '0;
      k_q      <= '0;
      prev_q   <= '0;
    end else begin
      if (state == IDLE && start && !start_bad) begin
        n_q <= n_value;
        k_q <= k_value;
      end
      if (out_valid && out_ready && !abort) begin
        prev_q <= out_pattern;
        if ($countones(out_pattern) != int'(k_q))
          chk_fail <= 1'b1;
        if (out_rank != '0 && out_pattern <= prev_q)
          chk_fail <= 1'b1;
      end
      if (done && !err && total_count != CNT_WIDTH'(meru_nk))
        chk_fail <= 1'b1;
    end
  end
`else
  assign chk_fail = 1'b0;
`endif

endmodule
